// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares the QSPI memory port between CPU and PCM fetch.
// Registered, transaction-locked, PCM-first with a CPU starvation guard.
module spi_mem_arbiter #(
  parameter int AW           = 24,
  parameter int DW           = 32,
  parameter bit PCM_PRIORITY = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_select,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          pcm_valid,
  input  logic [AW-1:0] pcm_addr,
  output logic          pcm_ready,
  output logic [7:0]    pcm_rdata,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_length,
  output logic          mem_select,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_PCM = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] starve_cnt, starve_n;
  logic       any_valid;
  logic       prio_valid;
  logic       other_valid;
  logic       pick_prio;
  logic       pick_pcm;
  logic       grant;

  // Winner selection: priority side unless the other side has waited too long.
  always_comb begin
    prio_valid  = PCM_PRIORITY ? pcm_valid : cpu_valid;
    other_valid = PCM_PRIORITY ? cpu_valid : pcm_valid;
    any_valid   = cpu_valid | pcm_valid;
    pick_prio   = prio_valid &&
                  (!other_valid || starve_cnt != LIM);
    pick_pcm    = PCM_PRIORITY ? pick_prio : !pick_prio;
    grant       = (state == IDLE) && any_valid;
  end

  // Next-state and starvation counter update.
  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          state_n = pick_pcm ? GNT_PCM : GNT_CPU;
          if (pick_prio && other_valid && starve_cnt != LIM)
            starve_n = starve_cnt + 4'd1;
          else if (!pick_prio)
            starve_n = 4'd0;
        end
      end
      GNT_CPU: if (mem_ready) state_n = IDLE;
      GNT_PCM: if (mem_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
    end
  end

  // Command latch: fields frozen from grant until mem_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_length <= 2'b00;
      mem_select <= 1'b0;
      owner      <= 2'b00;
    end else if (grant) begin
      mem_valid <= 1'b1;
      if (pick_pcm) begin
        mem_addr   <= pcm_addr;
        mem_we     <= 1'b0;
        mem_wdata  <= '0;
        mem_length <= 2'b00;
        mem_select <= 1'b1;
        owner      <= 2'b10;
      end else begin
        mem_addr   <= cpu_addr;
        mem_we     <= cpu_we;
        mem_wdata  <= cpu_wdata;
        mem_length <= 2'b11;
        mem_select <= cpu_select;
        owner      <= 2'b01;
      end
    end else if (state != IDLE && mem_ready) begin
      mem_valid <= 1'b0;
      owner     <= 2'b00;
    end
  end

  // Completion strobes go straight from mem_ready to the owner.
  always_comb begin
    cpu_ready = (state == GNT_CPU) && mem_ready;
    pcm_ready = (state == GNT_PCM) && mem_ready;
    cpu_rdata = cpu_ready ? mem_rdata : '0;
    pcm_rdata = pcm_ready ? mem_rdata[7:0] : 8'h00;
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed checks of grant order, latching,
// starvation guard, async reset and spurious ready.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid, cpu_we, cpu_select;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        pcm_valid;
  logic [23:0] pcm_addr;
  logic        pcm_ready;
  logic [7:0]  pcm_rdata;
  logic        mem_valid, mem_we, mem_select;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_length;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_select(cpu_select), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .pcm_valid(pcm_valid), .pcm_addr(pcm_addr),
    .pcm_ready(pcm_ready), .pcm_rdata(pcm_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_length(mem_length), .mem_select(mem_select),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_valid = 0; cpu_we = 0; cpu_select = 0;
    cpu_addr = '0; cpu_wdata = '0;
    pcm_valid = 0; pcm_addr = '0;
    mem_ready = 0; mem_rdata = '0;
    #12;
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_length", 32'(mem_length), 0);
    chk("rst_readys", 32'({cpu_ready, pcm_ready}), 0);
    step();
    rst = 1'b0;

    // single CPU read
    step();
    cpu_valid = 1; cpu_addr = 24'h100000; cpu_select = 0;
    step();
    chk("t1_mem_valid", 32'(mem_valid), 1);
    chk("t1_length", 32'(mem_length), 3);
    chk("t1_owner", 32'(owner), 1);
    chk("t1_addr", 32'(mem_addr), 32'h100000);
    chk("t1_we", 32'(mem_we), 0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_cpu_ready", 32'(cpu_ready), 1);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_pcm_ready", 32'(pcm_ready), 0);
    step();
    mem_ready = 0; cpu_valid = 0;
    #1;
    chk("t1_ready_pulse", 32'(cpu_ready), 0);
    chk("t1_idle_valid", 32'(mem_valid), 0);
    chk("t1_idle_owner", 32'(owner), 0);
    step();
    chk("t1_no_regrant", 32'(mem_valid), 0);

    // simultaneous requests: PCM first, then CPU
    cpu_valid = 1; cpu_addr = 24'h000800; cpu_select = 1;
    cpu_we = 0;
    pcm_valid = 1; pcm_addr = 24'h000200;
    step();
    chk("t2_owner_pcm", 32'(owner), 2);
    chk("t2_len_pcm", 32'(mem_length), 0);
    chk("t2_sel_pcm", 32'(mem_select), 1);
    chk("t2_we_pcm", 32'(mem_we), 0);
    chk("t2_addr_pcm", 32'(mem_addr), 32'h200);
    mem_ready = 1; mem_rdata = 32'h112233A5;
    #1;
    chk("t2_pcm_ready", 32'(pcm_ready), 1);
    chk("t2_pcm_rdata", 32'(pcm_rdata), 32'hA5);
    chk("t2_cpu_ready0", 32'(cpu_ready), 0);
    step();
    mem_ready = 0; pcm_valid = 0;
    #1;
    chk("t2_dead_cycle", 32'(mem_valid), 0);
    step();
    chk("t2_owner_cpu", 32'(owner), 1);
    chk("t2_addr_cpu", 32'(mem_addr), 32'h800);
    chk("t2_sel_cpu", 32'(mem_select), 1);
    mem_ready = 1;
    step();
    mem_ready = 0; cpu_valid = 0;
    step();

    // starvation guard: PCM x4 then CPU
    cpu_valid = 1; cpu_addr = 24'h000010; cpu_select = 0;
    pcm_valid = 1; pcm_addr = 24'h000020;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_owner_%0d", i), 32'(owner),
          (i < 4) ? 32'd2 : 32'd1);
      if (i == 4)
        chk("t3_starve_clr", 32'(dut.starve_cnt), 0);
      mem_ready = 1;
      #1;
      chk($sformatf("t3_ready_%0d", i),
          32'({cpu_ready, pcm_ready}),
          (i < 4) ? 32'd1 : 32'd2);
      step();
      mem_ready = 0;
    end
    cpu_valid = 0; pcm_valid = 0;
    step();

    // field stability on a CPU write
    cpu_valid = 1; cpu_we = 1; cpu_select = 1;
    cpu_addr = 24'h000040; cpu_wdata = 32'h12345678;
    step();
    chk("t4_addr0", 32'(mem_addr), 32'h40);
    chk("t4_wdata0", mem_wdata, 32'h12345678);
    chk("t4_we0", 32'(mem_we), 1);
    cpu_addr = 24'hABCDEF; cpu_wdata = 32'h0; cpu_valid = 0;
    cpu_we = 0;
    step();
    step();
    chk("t4_valid_held", 32'(mem_valid), 1);
    chk("t4_addr1", 32'(mem_addr), 32'h40);
    chk("t4_wdata1", mem_wdata, 32'h12345678);
    chk("t4_we1", 32'(mem_we), 1);
    chk("t4_len1", 32'(mem_length), 3);
    mem_ready = 1;
    #1;
    chk("t4_cpu_ready", 32'(cpu_ready), 1);
    step();
    mem_ready = 0;
    step();

    // async reset while PCM owns the port
    pcm_valid = 1; pcm_addr = 24'h000300;
    step();
    chk("t5_owner_pcm", 32'(owner), 2);
    cpu_valid = 1; cpu_addr = 24'h000500; cpu_select = 0;
    #2;
    rst = 1;
    #1;
    chk("t5_rst_valid", 32'(mem_valid), 0);
    chk("t5_rst_owner", 32'(owner), 0);
    pcm_valid = 0;
    step();
    rst = 0;
    step();
    chk("t5_cpu_grant", 32'(owner), 1);
    chk("t5_cpu_addr", 32'(mem_addr), 32'h500);
    mem_ready = 1;
    step();
    mem_ready = 0; cpu_valid = 0;
    step();

    // spurious mem_ready in IDLE
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("t6_readys", 32'({cpu_ready, pcm_ready}), 0);
    step();
    chk("t6_valid", 32'(mem_valid), 0);
    chk("t6_owner", 32'(owner), 0);
    mem_ready = 0;
    step();
    chk("t6_still_idle", 32'(mem_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single QSPI memory port (spi_mem: flash/PSRAM) between the CPU memory requester and the YM2610 PCM fetch requester.
- Replaces the combinational "cpu valid wins" mux in top with a registered, transaction-locked arbiter.
- Arbitration favours PCM by default to meet sample deadlines, with a bounded-starvation guard for the CPU.
- Latches each granted request so that spi_mem sees command fields that stay stable until mem_ready.

Parameters:
- AW, 24, memory address width.
- DW, 32, data width.
- PCM_PRIORITY, 1, 1 = PCM wins when both request; 0 = CPU wins.
- STARVE_LIMIT, 4, maximum consecutive grants to the priority requester while the other waits (range 1..15).

Ports:
- clk  in  1  system clock (24 MHz domain).
- rst  in  1  asynchronous reset, active-high.
- cpu_valid  in  1  CPU request.
- cpu_addr  in  AW  CPU address.
- cpu_we  in  1  CPU write.
- cpu_wdata  in  DW  CPU write data.
- cpu_select  in  1  0 = flash, 1 = PSRAM.
- cpu_ready  out  1  CPU completion strobe.
- cpu_rdata  out  DW  CPU read data.
- pcm_valid  in  1  PCM fetch request (always a read).
- pcm_addr  in  AW  PCM address.
- pcm_ready  out  1  PCM completion strobe.
- pcm_rdata  out  8  PCM byte (mem_rdata[7:0]).
- mem_valid  out  1  to spi_mem.
- mem_addr  out  AW  to spi_mem.
- mem_we  out  1  to spi_mem.
- mem_wdata  out  DW  to spi_mem.
- mem_length  out  2  2'b11 for CPU, 2'b00 for PCM.
- mem_select  out  1  CPU value for CPU, 1 for PCM.
- mem_ready  in  1  from spi_mem.
- mem_rdata  in  DW  from spi_mem.
- owner  out  2  debug: 00 = idle, 01 = CPU, 10 = PCM.

Behaviour:
- Reset (asynchronous): state IDLE. Outputs mem_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, mem_length=0, mem_select=0, cpu_ready=0, pcm_ready=0, owner=00. Starvation counter starve_cnt=0.
- States:
  - IDLE: evaluates requests every cycle. If any requester is valid, latches the winner's fields into the mem_* registers, sets mem_valid=1 on the next clock edge and moves to GNT_CPU or GNT_PCM. Latency from valid to mem_valid is 1 cycle.
  - GNT_x: holds mem_* constant until mem_ready=1. In the mem_ready cycle, x_ready=1 combinationally and x_rdata=mem_rdata. The other ready stays 0. On that edge: mem_valid<=0, owner<=00, return to IDLE.
  - IDLE always lasts at least 1 cycle. Back-to-back service therefore has one dead cycle, and the requester's still-high valid during its own ready cycle is never re-sampled as a new request.
- Winner selection in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the priority side (PCM if PCM_PRIORITY=1) wins unless starve_cnt==STARVE_LIMIT, in which case the other side wins.
- starve_cnt rules, applied at each grant:
  - Incremented when the priority side is granted while the other side is valid.
  - Cleared when the non-priority side is granted.
  - Unchanged when the priority side is granted with the other side idle.
  - Saturates at STARVE_LIMIT.
- CPU write data is taken only from the latch. mem_wdata and mem_we are 0 for PCM grants. mem_ready seen in IDLE is ignored.
- Requesters must hold valid until ready. If the granted requester drops valid early, the latched transaction still runs to mem_ready, and the ready pulse is still issued (harmless). Field changes after the grant are ignored.
- No timeout: if spi_mem never asserts ready, the arbiter stalls in GNT_x.
- Reset mid-transaction returns immediately to IDLE with mem_valid=0. spi_mem is reset by the same rst.

Test Plan:
- Single CPU read: cpu_valid with addr=0x100000, select=0. Next cycle: mem_valid=1, mem_length=11, owner=01. After mem_ready with rdata=0xDEADBEEF: cpu_ready=1 for 1 cycle, cpu_rdata=0xDEADBEEF, pcm_ready=0.
- Simultaneous requests with PCM_PRIORITY=1: first grant goes to PCM (mem_length=00, mem_select=1, mem_we=0). After its ready and 1 IDLE cycle, CPU is granted.
- Starvation, STARVE_LIMIT=4: cpu_valid held high, PCM re-requests immediately after each ready. Grants are PCM×4 then CPU, and starve_cnt=0 after the CPU grant.
- Field stability: CPU write addr=0x000040, wdata=0x12345678. Change cpu_addr/cpu_wdata and drop cpu_valid during the wait. mem_addr, mem_wdata and mem_we=1 stay unchanged until mem_ready.
- Asynchronous rst asserted in GNT_PCM: mem_valid=0 and owner=00 without waiting for a clock edge. After release, a pending cpu_valid is granted 1 cycle later.
- Spurious mem_ready in IDLE with no requests: cpu_ready=pcm_ready=0, state stays IDLE.
